// File: rtl/pulse_to_level_stretcher_pkg.sv
// Shared definitions for the pulse-to-level stretcher.
// State encoding and default counter width.
package pulse_stretch_pkg;

    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

endpackage

// File: rtl/pulse_to_level_stretcher_if.sv
// Trigger/level bundle between a strobe source and the stretcher.
// The master drives triggers and length; the slave returns the level and status.
interface pulse_to_level_stretcher_if #(
    parameter int CNT_W = 8
);

    logic             pulse_in;
    logic [CNT_W-1:0] len;
    logic             level_out;
    logic             busy;
    logic             overrun;

    modport master (
        output pulse_in,
        output len,
        input  level_out,
        input  busy,
        input  overrun
    );

    modport slave (
        input  pulse_in,
        input  len,
        output level_out,
        output busy,
        output overrun
    );

endinterface

// File: rtl/pulse_to_level_stretcher_load_down_counter.sv
// Loadable down-counter with a zero flag.
// Load wins over decrement; the owner never decrements at zero.
module load_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: clear, load or step down.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_to_level_stretcher.sv
// Stretches single-cycle triggers into a level of programmable width,
// with optional retrigger and a dead window after each level.
import pulse_stretch_pkg::*;

module pulse_to_level_stretcher #(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RETRIGGER = 0,
    parameter int HOLDOFF   = 2
) (
    input logic                       clk,
    input logic                       reset,
    pulse_to_level_stretcher_if.slave bus
);

    localparam bit         RETRIG  = (RETRIGGER != 0);
    localparam bit         HAS_GAP = (HOLDOFF != 0);
    localparam logic [7:0] GAP_LD  = 8'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic             reg_pulse;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] len_ld;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             gcnt_load;
    logic             gcnt_dec;
    logic             gcnt_zero;
    logic             drop;
    logic             level_q;
    logic             busy_q;
    logic             overrun_q;

    // A zero length behaves as a one-cycle stretch.
    assign len_ld = (bus.len == '0) ? '0 : bus.len - CNT_W'(1);

    // Input register: the FSM only ever sees the delayed trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_pulse <= 1'b0;
        end else begin
            reg_pulse <= bus.pulse_in;
        end
    end

    // Next-state and counter control; a reload beats the exit on the last cycle.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        gcnt_load = 1'b0;
        gcnt_dec  = 1'b0;
        drop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reg_pulse) begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (reg_pulse && RETRIG) begin
                    cnt_load = 1'b1;
                end else begin
                    drop = reg_pulse;
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (HAS_GAP) begin
                        gcnt_load = 1'b1;
                        state_nxt = ST_GAP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                drop = reg_pulse;
                if (gcnt_zero) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gcnt_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            level_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            level_q   <= (state_nxt == ST_ACTIVE);
            busy_q    <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_GAP);
            overrun_q <= drop;
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

    load_down_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (len_ld),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    load_down_counter #(
        .W (8)
    ) u_gcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gcnt_load),
        .load_val (GAP_LD),
        .dec      (gcnt_dec),
        .zero     (gcnt_zero)
    );

endmodule

// File: tb/tb_pulse_to_level_stretcher.sv
// Directed bench: two stretchers (drop and retrigger) driven from
// per-cycle pulse/reset masks against hand-derived output masks.
module tb_pulse_to_level_stretcher;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    pulse_to_level_stretcher_if #(.CNT_W(8)) b0 ();
    pulse_to_level_stretcher_if #(.CNT_W(8)) b1 ();

    pulse_to_level_stretcher #(
        .CNT_W     (8),
        .RETRIGGER (0),
        .HOLDOFF   (2)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    pulse_to_level_stretcher #(
        .CNT_W     (8),
        .RETRIGGER (1),
        .HOLDOFF   (2)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed bit with its expectation.
    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] rng(input int lo, input int hi);
        logic [39:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [39:0] at(input int c);
        logic [39:0] m;
        m = '0;
        m[c] = 1'b1;
        return m;
    endfunction

    task automatic drive(input logic p, input logic r);
        b0.pulse_in = p;
        b1.pulse_in = p;
        reset = r;
    endtask

    // Three reset cycles with quiet outputs expected throughout.
    task automatic do_reset(input string name);
        @(negedge clk);
        drive(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("%s rst%0d lvl0", name, i), b0.level_out, 1'b0);
            chk($sformatf("%s rst%0d busy0", name, i), b0.busy, 1'b0);
            chk($sformatf("%s rst%0d ovr0", name, i), b0.overrun, 1'b0);
            chk($sformatf("%s rst%0d lvl1", name, i), b1.level_out, 1'b0);
            chk($sformatf("%s rst%0d busy1", name, i), b1.busy, 1'b0);
        end
        drive(1'b0, 1'b0);
    endtask

    // Run 40 cycles; cycle c inputs are driven and outputs checked mid-cycle.
    task automatic run_case(
        input string       name,
        input bit          sel,
        input logic [7:0]  l,
        input logic [39:0] pm,
        input logic [39:0] rm,
        input logic [39:0] lm,
        input logic [39:0] bm,
        input logic [39:0] om
    );
        logic lv, bz, ov;
        do_reset(name);
        b0.len = l;
        b1.len = l;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            drive(pm[c], rm[c]);
            lv = sel ? b1.level_out : b0.level_out;
            bz = sel ? b1.busy : b0.busy;
            ov = sel ? b1.overrun : b0.overrun;
            chk($sformatf("%s c%0d level", name, c), lv, lm[c]);
            chk($sformatf("%s c%0d busy", name, c), bz, bm[c]);
            chk($sformatf("%s c%0d overrun", name, c), ov, om[c]);
        end
        drive(1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        b0.len = '0;
        b1.len = '0;
        drive(1'b0, 1'b1);

        run_case("idle", 1'b0, 8'd5, '0, '0, '0, '0, '0);

        run_case("len5", 1'b0, 8'd5, at(10), '0,
                 rng(12, 16), rng(12, 18), '0);

        run_case("len0", 1'b0, 8'd0, at(10), '0,
                 at(12), rng(12, 14), '0);

        run_case("drop", 1'b0, 8'd4, at(10) | at(12) | at(16), '0,
                 rng(12, 15), rng(12, 17), at(14) | at(18));

        run_case("gapend", 1'b0, 8'd4, at(10) | at(17), '0,
                 rng(12, 15) | rng(19, 22),
                 rng(12, 17) | rng(19, 24), '0);

        run_case("retrig", 1'b1, 8'd4, at(10) | at(13), '0,
                 rng(12, 18), rng(12, 20), '0);

        run_case("retlast", 1'b1, 8'd4, at(10) | at(14) | at(20), '0,
                 rng(12, 19), rng(12, 21), at(22));

        run_case("midrst", 1'b0, 8'd10, at(10) | at(20), at(15),
                 rng(12, 15) | rng(22, 31),
                 rng(12, 15) | rng(22, 33), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
